fifo_tx_scheduler: RTL and testbench

Drains the 8-entry byte FIFO into a byte-serial transmitter (UART TX) one byte at a time. It pops a byte, holds it stable on tx_data, issues a start pulse, waits for completion, then enforces a programmable inter-byte gap. It sits between the FIFO read side (rd/rdata/empty) and the UART TX start/busy/done interface. It also supports a flush (discard) mode and a completion-timeout watchdog.

---
 rtl/fifo_tx_scheduler.sv | 147 ++++++++++++++
 tb/tb_fifo_tx_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_scheduler.sv
// fifo_tx_scheduler: drains a show-ahead byte FIFO into a byte-serial
// transmitter. It pops one byte, holds it on tx_data, pulses tx_start,
// waits for tx_done, and then inserts an optional inter-byte gap.
// A flush mode discards FIFO contents. A watchdog aborts a byte whose
// tx_done never arrives.
module fifo_tx_scheduler #(
    parameter int DWIDTH     = 8,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 200000,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [DWIDTH-1:0] tx_data,
    output logic              idle,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  sent_cnt
);

    // The watchdog counter only has to reach TIMEOUT-1.
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The gap counter only has to reach GAP_CYCLES-1.
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT,
        S_GAP,
        S_FLUSH
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [TO_W-1:0]   to_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              to_expire;

    // The watchdog fires only when tx_done is absent, so a done that arrives
    // on the expiry clock counts as a good completion.
    assign to_expire = (state == S_WAIT) && !tx_done && (to_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and state-decoded strobes
    always_comb begin
        state_nx = state;
        fifo_rd  = 1'b0;
        tx_start = 1'b0;
        idle     = 1'b0;
        case (state)
            S_IDLE: begin
                idle = 1'b1;
                if (flush && !fifo_empty) begin
                    state_nx = S_FLUSH;
                end else if (en && !fifo_empty) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                fifo_rd  = !fifo_empty;
                state_nx = S_START;
            end
            S_START: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    state_nx = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else if (to_expire) begin
                    state_nx = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = S_IDLE;
                end
            end
            S_FLUSH: begin
                fifo_rd = !fifo_empty;
                if (fifo_empty || !flush) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Byte capture, gap and watchdog counters, error flag, and completion count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data     <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
            sent_cnt    <= '0;
        end else begin
            if (state == S_FETCH) begin
                tx_data <= fifo_rdata;
            end

            if (tx_start) begin
                to_cnt <= '0;
            end else if (state == S_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if (to_expire) begin
                timeout_err <= 1'b1;
            end

            if ((state == S_WAIT) && tx_done) begin
                sent_cnt <= sent_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Directed testbench for fifo_tx_scheduler. It uses a behavioural FIFO, a
// stub transmitter (busy for 10 clocks, then a one-clock done pulse), and
// an edge monitor that logs tx_start cycles/data, tx_done cycles, and pops.
module tb_fifo_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;
    logic       tx_busy;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       idle;
    logic       timeout_err;
    logic [3:0] sent_cnt;

    logic       force_busy;
    logic       no_done;
    logic       stub_busy = 1'b0;
    int         stub_cnt = 0;

    logic [7:0] mem [0:255];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;

    int         cyc = 0;
    int         start_n = 0;
    int         done_n = 0;
    int         rd_n = 0;
    int         bad_rd = 0;
    int         start_cyc [0:63];
    int         done_cyc [0:63];
    logic [7:0] start_data [0:63];

    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    fifo_tx_scheduler #(
        .DWIDTH    (8),
        .GAP_CYCLES(4),
        .TIMEOUT   (16),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .idle       (idle),
        .timeout_err(timeout_err),
        .sent_cnt   (sent_cnt)
    );

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr];
    assign tx_busy    = stub_busy | force_busy;

    // Stub transmitter
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (tx_start) begin
            stub_cnt  <= 10;
            stub_busy <= 1'b1;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                stub_busy <= 1'b0;
                tx_done   <= !no_done;
            end
        end
    end

    // FIFO pop side and event monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            rd_ptr <= rd_ptr + 8'd1;
            rd_n   <= rd_n + 1;
            if (fifo_empty) bad_rd <= bad_rd + 1;
        end
        if (tx_start) begin
            start_cyc[start_n]  <= cyc;
            start_data[start_n] <= tx_data;
            start_n             <= start_n + 1;
        end
        if (tx_done) begin
            done_cyc[done_n] <= cyc;
            done_n           <= done_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_drain(input int max, input string tag);
        int n;
        n = 0;
        step;
        while (!(idle && fifo_empty && !tx_busy) && n < max) begin
            step;
            n++;
        end
        check(tag, {31'd0, idle && fifo_empty}, 32'd1);
    endtask

    task automatic wait_start(input int base, input int max, input string tag);
        int n;
        n = 0;
        step;
        while (start_n <= base && n < max) begin
            step;
            n++;
        end
        check(tag, {31'd0, start_n > base}, 32'd1);
    endtask

    initial begin
        int base;
        int dbase;
        int rbase;
        int push_cyc;
        int hold_bad;
        int k;

        rst_n      = 1'b0;
        en         = 1'b1;
        flush      = 1'b0;
        force_busy = 1'b0;
        no_done    = 1'b0;
        step;
        step;

        // Reset values
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_sent_cnt", {28'd0, sent_cnt}, 32'd0);
        rst_n = 1'b1;
        step;

        // Test 1: three bytes in order, 2-clock start latency
        base     = start_n;
        rbase    = rd_n;
        push_cyc = cyc;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        wait_drain(300, "t1_drain");
        check("t1_latency", start_cyc[base] - push_cyc, 32'd2);
        check("t1_byte0", {24'd0, start_data[base]}, 32'h41);
        check("t1_byte1", {24'd0, start_data[base+1]}, 32'h42);
        check("t1_byte2", {24'd0, start_data[base+2]}, 32'h43);
        check("t1_starts", start_n - base, 32'd3);
        check("t1_pops", rd_n - rbase, 32'd3);
        check("t1_sent_cnt", {28'd0, sent_cnt}, 32'd3);
        check("t1_idle", {31'd0, idle}, 32'd1);

        // Test 2: done-to-next-start spacing = 4 gap + IDLE + FETCH, then start
        base  = start_n;
        dbase = done_n;
        push(8'hA1);
        push(8'hA2);
        wait_drain(300, "t2_drain");
        check("t2_done_to_start", start_cyc[base+1] - done_cyc[dbase], 32'd7);
        check("t2_byte1", {24'd0, start_data[base+1]}, 32'hA2);
        check("t2_sent_cnt", {28'd0, sent_cnt}, 32'd5);

        // Test 3: hold in START while busy, even with en dropped
        base       = start_n;
        force_busy = 1'b1;
        push(8'h5A);
        step;
        step;
        check("t3_in_start", {31'd0, idle}, 32'd0);
        check("t3_data_loaded", {24'd0, tx_data}, 32'h5A);
        en       = 1'b0;
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (tx_start !== 1'b0) hold_bad++;
            if (tx_data !== 8'h5A) hold_bad++;
        end
        check("t3_hold", hold_bad, 32'd0);
        force_busy = 1'b0;
        #1;
        check("t3_start_on_release", {31'd0, tx_start}, 32'd1);
        step;
        check("t3_start_one_clock", {31'd0, tx_start}, 32'd0);
        wait_drain(300, "t3_drain");
        check("t3_starts", start_n - base, 32'd1);
        check("t3_sent_cnt", {28'd0, sent_cnt}, 32'd6);

        // Test 4a: flush five bytes with en=0
        base  = start_n;
        rbase = rd_n;
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        step;
        step;
        check("t4_en0_no_pop", rd_n - rbase, 32'd0);
        flush = 1'b1;
        wait_drain(100, "t4_drain");
        flush = 1'b0;
        check("t4_pops", rd_n - rbase, 32'd5);
        check("t4_no_start", start_n - base, 32'd0);
        check("t4_sent_cnt", {28'd0, sent_cnt}, 32'd6);

        // Test 4b: flush raised mid-WAIT completes the byte in flight
        en    = 1'b1;
        base  = start_n;
        rbase = rd_n;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_start(base, 50, "t4b_start");
        flush = 1'b1;
        wait_drain(200, "t4b_drain");
        flush = 1'b0;
        check("t4b_starts", start_n - base, 32'd1);
        check("t4b_byte", {24'd0, start_data[base]}, 32'h11);
        check("t4b_pops", rd_n - rbase, 32'd3);
        check("t4b_sent_cnt", {28'd0, sent_cnt}, 32'd7);

        // Test 5: watchdog expiry after 16 WAIT clocks, then normal recovery
        no_done = 1'b1;
        base    = start_n;
        push(8'h77);
        wait_start(base, 50, "t5_start");
        k = 0;
        while (!timeout_err && k < 40) begin
            step;
            k++;
        end
        check("t5_expiry_clock", k, 32'd16);
        check("t5_idle", {31'd0, idle}, 32'd1);
        check("t5_sent_cnt", {28'd0, sent_cnt}, 32'd7);
        wait_drain(100, "t5_settle");
        no_done = 1'b0;
        base    = start_n;
        push(8'h99);
        wait_drain(200, "t5_drain");
        check("t5_next_byte", {24'd0, start_data[base]}, 32'h99);
        check("t5_sent_after", {28'd0, sent_cnt}, 32'd8);
        check("t5_err_sticky", {31'd0, timeout_err}, 32'd1);

        // Test 6: asynchronous reset mid-WAIT
        base = start_n;
        push(8'hFF);
        wait_start(base, 50, "t6_start");
        step;
        step;
        rst_n = 1'b0;
        #1;
        check("t6_async_idle", {31'd0, idle}, 32'd1);
        check("t6_async_tx_data", {24'd0, tx_data}, 32'h0);
        check("t6_async_err", {31'd0, timeout_err}, 32'd0);
        check("t6_async_sent", {28'd0, sent_cnt}, 32'd0);
        check("t6_async_start", {31'd0, tx_start}, 32'd0);
        repeat (15) step;
        rst_n = 1'b1;
        base  = start_n;
        repeat (5) step;
        check("t6_no_spurious", start_n - base, 32'd0);
        push(8'h3C);
        wait_drain(200, "t6_drain");
        check("t6_restart_byte", {24'd0, start_data[base]}, 32'h3C);
        check("t6_sent_one", {28'd0, sent_cnt}, 32'd1);

        // Sixteen more bytes: 17 total since reset wraps a 4-bit count to 1
        for (int i = 0; i < 16; i++) push(8'(i));
        wait_drain(1500, "t6_wrap_drain");
        check("t6_wrap_sent", {28'd0, sent_cnt}, 32'd1);
        check("t6_wrap_starts", start_n - base, 32'd17);
        check("t6_wrap_last", {24'd0, start_data[base+16]}, 32'h0F);
        check("no_pop_when_empty", bad_rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
